// File: rtl/mpy_share_pkg.sv
// rtl/mpy_share_pkg.sv - shared defaults, id-width helper and tag type for mpy_share_arb
// Purpose: common parameters and types for the shared-multiplier scheduler.
// Contents: default NA/NB/NREQ/LAT, idw_f() width helper, tag_t {valid, id}.
package mpy_share_pkg;

    localparam int NA_DEF    = 14;
    localparam int NB_DEF    = 16;
    localparam int NREQ_DEF  = 2;
    localparam int LAT_DEF   = 6;
    localparam int ID_MAX_W  = 3;    // enough for up to 8 requesters

    function automatic int idw_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/mpy_rr_pick.sv
// rtl/mpy_rr_pick.sv - combinational round-robin picker
// Purpose: grant the first requester with a request, searching from i_ptr upward modulo NREQ.
// Ports:
//   i_req   [NREQ] request vector
//   i_ptr   [IDW]  search start index
//   o_grant [NREQ] one-hot grant (0 when no request)
//   o_idx   [IDW]  encoded index of the grant
module mpy_rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx
);

    logic w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (int'(i_ptr) + i) % NREQ;
            if (!w_found && i_req[k]) begin
                w_found    = 1'b1;
                o_grant[k] = 1'b1;
                o_idx      = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/mpy_share_arb.sv
// rtl/mpy_share_arb.sv - round-robin scheduler time-sharing one pipelined signed multiplier
// Purpose: accept at most one operand pair per clock from NREQ requesters, drive the
//          external multiplier and route each product back to its issuer.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_req, i_a, i_b         per-requester request and packed signed operands
//   o_grant                 one-hot combinational grant
//   o_mpy_ce/a/b, i_mpy_p   multiplier interface (ce tied high)
//   o_valid, o_id, o_p      one-hot result strobe, owner index, registered product
//   o_busy                  any accepted operation still in flight
module mpy_share_arb
    import mpy_share_pkg::*;
#(
    parameter  int NA   = NA_DEF,
    parameter  int NB   = NB_DEF,
    parameter  int NREQ = NREQ_DEF,
    parameter  int LAT  = LAT_DEF,
    localparam int IDW  = idw_f(NREQ)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ*NA-1:0]   i_a,
    input  logic [NREQ*NB-1:0]   i_b,
    output logic [NREQ-1:0]      o_grant,
    output logic                 o_mpy_ce,
    output logic [NA-1:0]        o_mpy_a,
    output logic [NB-1:0]        o_mpy_b,
    input  logic [NA+NB-1:0]     i_mpy_p,
    output logic [NREQ-1:0]      o_valid,
    output logic [IDW-1:0]       o_id,
    output logic [NA+NB-1:0]     o_p,
    output logic                 o_busy
);

    logic [IDW-1:0]    r_ptr;
    logic [NA-1:0]     r_mpy_a;
    logic [NB-1:0]     r_mpy_b;
    logic [NREQ-1:0]   r_valid;
    logic [IDW-1:0]    r_id;
    logic [NA+NB-1:0]  r_p;
    // Entry 0 travels with the operand registers; entries 1..LAT follow the
    // multiplier stages, so entry LAT lines up with i_mpy_p.
    tag_t              r_tag [0:LAT];

    logic [NREQ-1:0]   w_pick;
    logic [IDW-1:0]    w_idx;
    logic              w_accept;
    logic [IDW-1:0]    w_ptr_next;

    mpy_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick),
        .o_idx   (w_idx)
    );

    assign o_grant    = i_reset ? '0 : w_pick;
    assign w_accept   = |o_grant;
    assign w_ptr_next = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr   <= '0;
            r_mpy_a <= '0;
            r_mpy_b <= '0;
            r_valid <= '0;
            r_id    <= '0;
            r_p     <= '0;
            for (int s = 0; s <= LAT; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_ptr    <= w_ptr_next;
                r_mpy_a  <= i_a[w_idx*NA +: NA];
                r_mpy_b  <= i_b[w_idx*NB +: NB];
                r_tag[0] <= '{valid: 1'b1, id: ID_MAX_W'(w_idx)};
            end else begin
                r_tag[0] <= '0;
            end
            for (int s = 1; s <= LAT; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
            // o_p / o_id only move on a real result so they hold between strobes.
            if (r_tag[LAT].valid) begin
                r_p     <= i_mpy_p;
                r_id    <= IDW'(r_tag[LAT].id);
                r_valid <= NREQ'(1) << r_tag[LAT].id;
            end else begin
                r_valid <= '0;
            end
        end
    end

    always_comb begin
        o_busy = |r_valid;
        for (int s = 0; s <= LAT; s++) begin
            o_busy = o_busy | r_tag[s].valid;
        end
    end

    assign o_mpy_ce = 1'b1;
    assign o_mpy_a  = r_mpy_a;
    assign o_mpy_b  = r_mpy_b;
    assign o_valid  = r_valid;
    assign o_id     = r_id;
    assign o_p      = r_p;

endmodule
